contador_bcd_botones: RTL and testbench

//  Upstream stage of the 7-segment decoder: turns two raw push-buttons into one BCD digit 0..9.
//  Per button: synchronise, debounce, then step the digit once on press; auto-repeat while held.

---
 rtl/contador_pkg.sv | 31 +++
 rtl/antirrebote.sv | 69 ++++++
 rtl/contador_bcd_botones.sv | 170 +++++++++++++++++
 tb/tb_contador_bcd_botones.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared types and helpers for the push-button BCD counter.
//   rep_state_t : per-button auto-repeat state
//   DIGIT_W     : width of the digit and of all digit arithmetic
//   step_up / step_down : 4-bit wrap-around digit arithmetic with an explicit
//                         compare against the wrap point
// ---------------------------------------------------------------------------
package contador_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_REP,
      REPEAT
   } rep_state_t;

   // Next digit for an up step: wraps from max_v back to zero.
   function automatic logic [DIGIT_W-1:0] step_up(input logic [DIGIT_W-1:0] v,
                                                  input logic [DIGIT_W-1:0] max_v);
      return (v == max_v) ? '0 : v + DIGIT_W'(1);
   endfunction

   // Next digit for a down step: wraps from zero up to max_v.
   function automatic logic [DIGIT_W-1:0] step_down(input logic [DIGIT_W-1:0] v,
                                                    input logic [DIGIT_W-1:0] max_v);
      return (v == '0) ? max_v : v - DIGIT_W'(1);
   endfunction

endpackage

// File: rtl/antirrebote.sv
// ---------------------------------------------------------------------------
// antirrebote
// Synchroniser + debouncer + rising-edge detect for one raw push-button.
// Ports:
//   clk    in  single clock, posedge
//   rst    in  synchronous reset, active-high
//   raw_in in  raw button, asynchronous to clk, bouncy
//   level  out debounced level (registered)
//   rise   out high in the cycle whose clock edge sets level from 0 to 1,
//              so a consumer registering on that same edge sees the press
//              at the same time as the level flips
// ---------------------------------------------------------------------------
module antirrebote
   import contador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_in,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   // Next-state logic: the two-flop synchroniser shifts the raw input in;
   // the debounce counter only runs while the synced value disagrees with the
   // debounced level, and the level flips once it has disagreed for
   // DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers; reset discards any debounce progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level = level_q;
   assign rise  = level_d & ~level_q;

endmodule

// File: rtl/contador_bcd_botones.sv
// ---------------------------------------------------------------------------
// contador_bcd_botones
// Turns two raw push-buttons into one BCD digit 0..MAX_DIGIT for the
// 7-segment decoder. Each button is debounced, steps the digit once on
// press and auto-repeats while held.
// Ports:
//   clk       in  single clock, posedge
//   rst       in  synchronous reset, active-high
//   btn_up    in  raw button, active-high, asynchronous, bouncy
//   btn_down  in  raw button, active-high, asynchronous, bouncy
//   load      in  synchronous load strobe
//   load_val  in  [3:0] value taken when load=1
//   digito    out [3:0] current digit (digito[3]=sw1 MSB .. digito[0]=sw4 LSB)
//   carry     out 1-cycle pulse on an up wrap MAX_DIGIT->0
//   borrow    out 1-cycle pulse on a down wrap 0->MAX_DIGIT
//   load_err  out 1-cycle pulse when a load value is out of range
// ---------------------------------------------------------------------------
module contador_bcd_botones
   import contador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000,
   parameter int MAX_DIGIT       = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   output logic [DIGIT_W-1:0] digito,
   output logic               carry,
   output logic               borrow,
   output logic               load_err
);

   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

   // Index 0 is the up button, index 1 the down button.
   logic [1:0] btn_level;
   logic [1:0] btn_rise;
   logic [1:0] step_req;

   antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_ar_up (
      .clk   (clk),
      .rst   (rst),
      .raw_in(btn_up),
      .level (btn_level[0]),
      .rise  (btn_rise[0])
   );

   antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_ar_down (
      .clk   (clk),
      .rst   (rst),
      .raw_in(btn_down),
      .level (btn_level[1]),
      .rise  (btn_rise[1])
   );

   for (genvar i = 0; i < 2; i++) begin : g_rep
      rep_state_t       state_q;
      logic [TMR_W-1:0] timer_q;
      logic             step_q;

      // Auto-repeat FSM for one button. The first step is issued on the
      // press itself, the second after REPEAT_DELAY cycles, and then one
      // every REPEAT_PERIOD cycles. One timer serves both waiting states and
      // is cleared on every step. Release returns to IDLE without a step.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
         end else begin
            step_q <= 1'b0;
            case (state_q)
               IDLE: begin
                  if (btn_rise[i]) begin
                     state_q <= WAIT_REP;
                     step_q  <= 1'b1;
                     timer_q <= '0;
                  end
               end
               WAIT_REP: begin
                  if (!btn_level[i]) begin
                     state_q <= IDLE;
                  end else if (timer_q == TMR_W'(REPEAT_DELAY - 1)) begin
                     state_q <= REPEAT;
                     step_q  <= 1'b1;
                     timer_q <= '0;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
               REPEAT: begin
                  if (!btn_level[i]) begin
                     state_q <= IDLE;
                  end else if (timer_q == TMR_W'(REPEAT_PERIOD - 1)) begin
                     step_q  <= 1'b1;
                     timer_q <= '0;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end

      assign step_req[i] = step_q;
   end

   logic [DIGIT_W-1:0] digito_q, digito_d;
   logic               carry_q, carry_d;
   logic               borrow_q, borrow_d;
   logic               load_err_q, load_err_d;

   // Step resolution: load beats any step; simultaneous up and down cancel;
   // otherwise a single step moves the digit, wrapping at the ends with a
   // carry or borrow pulse.
   always_comb begin
      digito_d   = digito_q;
      carry_d    = 1'b0;
      borrow_d   = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_val <= MAX_D) begin
            digito_d = load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (step_req[0] && !step_req[1]) begin
         digito_d = step_up(digito_q, MAX_D);
         carry_d  = (digito_q == MAX_D);
      end else if (step_req[1] && !step_req[0]) begin
         digito_d = step_down(digito_q, MAX_D);
         borrow_d = (digito_q == '0);
      end
   end

   // Registered outputs to the decoder.
   always_ff @(posedge clk) begin
      if (rst) begin
         digito_q   <= '0;
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         digito_q   <= digito_d;
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         load_err_q <= load_err_d;
      end
   end

   assign digito   = digito_q;
   assign carry    = carry_q;
   assign borrow   = borrow_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_contador_bcd_botones.sv
// ---------------------------------------------------------------------------
// tb_contador_bcd_botones
// Directed bench for contador_bcd_botones with short timing parameters
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, MAX_DIGIT=9).
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_contador_bcd_botones;

   logic       clk;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] digito;
   logic       carry;
   logic       borrow;
   logic       load_err;

   int assert_count = 0;
   int fail_count   = 0;

   contador_bcd_botones #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (8),
      .REPEAT_PERIOD  (3),
      .MAX_DIGIT      (9)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_up  (btn_up),
      .btn_down(btn_down),
      .load    (load),
      .load_val(load_val),
      .digito  (digito),
      .carry   (carry),
      .borrow  (borrow),
      .load_err(load_err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n clock cycles, returning on a falling edge.
   task automatic applyStimulus(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Compare all four outputs against the expected values at once.
   task automatic checkOutput(input string tag, input logic [3:0] exp_d,
                              input logic exp_c, input logic exp_b, input logic exp_e);
      logic [6:0] observed;
      logic [6:0] expected;
      observed = {digito, carry, borrow, load_err};
      expected = {exp_d, exp_c, exp_b, exp_e};
      assert_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s: observed digito=%0d carry=%b borrow=%b load_err=%b, expected digito=%0d carry=%b borrow=%b load_err=%b",
                tag, digito, carry, borrow, load_err, exp_d, exp_c, exp_b, exp_e);
      end
   endtask

   // Directed sequence; edge numbers in tags count rising edges since the
   // button/load change.
   initial begin
      rst      = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      load     = 1'b0;
      load_val = 4'd0;
      applyStimulus(2);
      rst = 1'b0;
      checkOutput("reset", 4'd0, 1'b0, 1'b0, 1'b0);

      // Clean hold of btn_up for 20 cycles: steps at edges 6, 14, 17, 20,
      // then two more at 23 and 26 while the release is being debounced.
      $display("[TB] clean hold of btn_up");
      btn_up = 1'b1;
      applyStimulus(6);
      checkOutput("hold_e6", 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("hold_e7_first", 4'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(7);
      checkOutput("hold_e14", 4'd1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("hold_e15_delay", 4'd2, 1'b0, 1'b0, 1'b0);
      applyStimulus(3);
      checkOutput("hold_e18_period", 4'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(2);
      btn_up = 1'b0;
      applyStimulus(1);
      checkOutput("hold_e21", 4'd4, 1'b0, 1'b0, 1'b0);
      applyStimulus(10);
      checkOutput("hold_released", 4'd6, 1'b0, 1'b0, 1'b0);

      // Bouncing input never stays stable long enough to register.
      $display("[TB] bouncing btn_up");
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("bounce_reset", 4'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         btn_up = (i % 2 == 0);
         applyStimulus(2);
      end
      btn_up = 1'b0;
      applyStimulus(10);
      checkOutput("bounce_done", 4'd0, 1'b0, 1'b0, 1'b0);

      // Load 9, then one press wraps to 0 with a single-cycle carry.
      $display("[TB] load 9 and up wrap");
      load     = 1'b1;
      load_val = 4'd9;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("load9", 4'd9, 1'b0, 1'b0, 1'b0);
      btn_up = 1'b1;
      applyStimulus(5);
      btn_up = 1'b0;
      applyStimulus(1);
      checkOutput("wrap_e6", 4'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("wrap_carry", 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("wrap_carry_end", 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(8);
      checkOutput("wrap_settled", 4'd0, 1'b0, 1'b0, 1'b0);

      // One down press from 0 wraps to 9 with a single-cycle borrow.
      $display("[TB] down wrap");
      btn_down = 1'b1;
      applyStimulus(5);
      btn_down = 1'b0;
      applyStimulus(1);
      checkOutput("down_e6", 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("down_borrow", 4'd9, 1'b0, 1'b1, 1'b0);
      applyStimulus(1);
      checkOutput("down_borrow_end", 4'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(8);

      // Out-of-range load holds the digit and flags an error for one cycle.
      $display("[TB] illegal load and load-vs-step");
      load     = 1'b1;
      load_val = 4'd12;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("load12_err", 4'd9, 1'b0, 1'b0, 1'b1);
      applyStimulus(1);
      checkOutput("load12_err_end", 4'd9, 1'b0, 1'b0, 1'b0);

      // Load asserted in the same cycle an up step is decided: load wins,
      // so the digit becomes 3 instead of wrapping to 0 with carry.
      btn_up = 1'b1;
      applyStimulus(5);
      btn_up = 1'b0;
      applyStimulus(1);
      load     = 1'b1;
      load_val = 4'd3;
      applyStimulus(1);
      load = 1'b0;
      checkOutput("load_beats_step", 4'd3, 1'b0, 1'b0, 1'b0);
      applyStimulus(8);
      checkOutput("load_step_settled", 4'd3, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of auto-repeat with the button still held.
      $display("[TB] reset during repeat");
      btn_up = 1'b1;
      applyStimulus(15);
      checkOutput("repeat_before_rst", 4'd5, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      rst = 1'b1;
      applyStimulus(1);
      rst = 1'b0;
      checkOutput("repeat_rst", 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(6);
      checkOutput("rst_redebounce_e6", 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1);
      checkOutput("rst_redebounce_e7", 4'd1, 1'b0, 1'b0, 1'b0);
      btn_up = 1'b0;
      applyStimulus(10);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
